alu: RTL and testbench
======================

ALU -- requirements
Module: alu

Interface
REQ-001 Parameters: none; all data widths fixed at 8 bits, opcode fixed at 4 bits.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 A  input  8  operand A, unsigned.
REQ-005 B  input  8  operand B, unsigned.
REQ-006 opcode  input  4  operation select.
REQ-007 ALU_Out  output  8  registered result.

Function
REQ-008 ALU_Out SHALL be a register loaded on every rising clk edge with f(opcode, A, B) sampled at that edge; latency exactly 1 cycle, no enable, no handshake.
REQ-009 Inputs SHALL be purely combinational into the result register; input changes between edges SHALL NOT alter ALU_Out until the next rising edge.
REQ-010 All arithmetic SHALL be unsigned, modulo 256; carry, borrow and overflow bits SHALL be discarded; no flag outputs.
REQ-011 Opcode 0000 ADD: A + B, low 8 bits.
REQ-012 Opcode 0001 SUB: A - B, two's-complement wrap (0 - 1 = 8'hFF).
REQ-013 Opcode 0010 MUL: low 8 bits of 16-bit product A * B.
REQ-014 Opcode 0011 DIV: floor(A / B); B = 0 SHALL yield 8'h00.
REQ-015 Opcode 0100 SHL: A << 1, zero fill; opcode 0101 SHR: A >> 1, zero fill.
REQ-016 Opcode 0110 ROL: A rotated left 1 bit; opcode 0111 ROR: A rotated right 1 bit.
REQ-017 Opcode 1000 AND, 1001 OR, 1010 XOR, 1011 NOR, 1100 NAND, 1101 XNOR: bitwise on A, B.
REQ-018 Opcode 1110 GT: 8'h01 if A > B else 8'h00.
REQ-019 Opcode 1111 EQ: 8'h01 if A == B else 8'h00.
REQ-020 Every 4-bit opcode value is defined; no X SHALL propagate to ALU_Out for known inputs.
REQ-021 Opcode changing on the same edge as operands: result SHALL use the values present at that edge only.

Reset
REQ-022 rst_n low SHALL force ALU_Out to 8'h00 immediately, independent of clk.
REQ-023 While rst_n is low, ALU_Out SHALL hold 8'h00 across clock edges.
REQ-024 After rst_n deasserts, the first rising edge SHALL load the normal result; deassertion coincident with an edge SHALL NOT corrupt the register (either 8'h00 or the correct result).
REQ-025 Reset asserted mid-operation SHALL discard the pending result; no other state exists.

Verification
REQ-026 ADD: A=8'h01,B=8'h01 -> 8'h02 after one edge; then A=8'h0A,B=8'h05 -> 8'h0F.
REQ-027 SUB: A=8'hFF,B=8'hFF -> 8'h00; A=8'h00,B=8'h01 -> 8'hFF (wrap); A=8'h0A,B=8'h05 -> 8'h05.
REQ-028 MUL/DIV: A=8'h10,B=8'h11 MUL -> 8'h10; A=8'h0F,B=8'h04 DIV -> 8'h03; A=8'h0F,B=8'h00 DIV -> 8'h00.
REQ-029 Shifts/logic: A=8'h81 ROL -> 8'h03, ROR -> 8'hC0, SHL -> 8'h02, SHR -> 8'h40; A=8'hF0,B=8'h3C AND -> 8'h30, XOR -> 8'hCC, NAND -> 8'hCF.
REQ-030 Compare: A=8'h05,B=8'h05 EQ -> 8'h01, GT -> 8'h00; A=8'h06,B=8'h05 GT -> 8'h01.
REQ-031 Reset: drive ADD result 8'h0F, pull rst_n low between edges -> ALU_Out 8'h00 before next edge, held while low; release -> correct result one edge later.

Source files
------------

// File: rtl/alu_if.sv
// Operand/result bundle for the 8-bit ALU.
// There is no valid/ready handshake: the ALU samples A, B and opcode on every rising edge.
interface alu_if;
  logic [7:0] A;
  logic [7:0] B;
  logic [3:0] opcode;
  logic [7:0] ALU_Out;

  modport master (output A, output B, output opcode, input ALU_Out);
  modport slave  (input A, input B, input opcode, output ALU_Out);
endinterface

// File: rtl/alu.sv
// 8-bit, 16-operation ALU with a single registered result.
// Unsigned modulo-256 arithmetic, one-cycle latency, async active-low clear.
module alu (
  input  logic  clk,
  input  logic  rst_n,
  alu_if.slave  bus
);

  logic [7:0] result;

  // Pure function of the operands; the only state is the output register below.
  always_comb begin
    result = 8'h00;
    case (bus.opcode)
      4'b0000: result = bus.A + bus.B;
      4'b0001: result = bus.A - bus.B;
      4'b0010: result = bus.A * bus.B;
      4'b0011: result = (bus.B == 8'h00) ? 8'h00 : bus.A / bus.B;
      4'b0100: result = {bus.A[6:0], 1'b0};
      4'b0101: result = {1'b0, bus.A[7:1]};
      4'b0110: result = {bus.A[6:0], bus.A[7]};
      4'b0111: result = {bus.A[0], bus.A[7:1]};
      4'b1000: result = bus.A & bus.B;
      4'b1001: result = bus.A | bus.B;
      4'b1010: result = bus.A ^ bus.B;
      4'b1011: result = ~(bus.A | bus.B);
      4'b1100: result = ~(bus.A & bus.B);
      4'b1101: result = ~(bus.A ^ bus.B);
      4'b1110: result = {7'b0000000, bus.A > bus.B};
      4'b1111: result = {7'b0000000, bus.A == bus.B};
      default: result = 8'h00;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.ALU_Out <= 8'h00;
    end else begin
      bus.ALU_Out <= result;
    end
  end

endmodule

// File: tb/tb_alu.sv
// Self-checking bench for alu: randomized operands against an arithmetic reference
// model, plus directed literal vectors and asynchronous reset scenarios.
module tb_alu;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_if bus();

  alu dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int pass_cnt = 0;
  int total_cnt = 0;
  logic [7:0] exp_q[$];
  logic [7:0] model_reg = 8'h00;

  // Reference model written with plain integer arithmetic.
  function automatic logic [7:0] ref_fn(input logic [3:0] op, input logic [7:0] a8, input logic [7:0] b8);
    int a;
    int b;
    int r;
    a = int'(a8);
    b = int'(b8);
    r = 0;
    case (int'(op))
      0:  r = (a + b) % 256;
      1:  r = (a - b + 256) % 256;
      2:  r = (a * b) % 256;
      3:  r = (b == 0) ? 0 : a / b;
      4:  r = (a * 2) % 256;
      5:  r = a / 2;
      6:  r = (a * 2) % 256 + a / 128;
      7:  r = a / 2 + (a % 2) * 128;
      8:  r = a & b;
      9:  r = a | b;
      10: r = a ^ b;
      11: r = 255 - (a | b);
      12: r = 255 - (a & b);
      13: r = 255 - (a ^ b);
      14: r = (a > b) ? 1 : 0;
      15: r = (a == b) ? 1 : 0;
      default: r = 0;
    endcase
    return 8'(r);
  endfunction

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] expv);
    total_cnt++;
    if (act === expv) pass_cnt++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
  endtask

  // Scoreboard: each sampling edge out of reset predicts the next visible output.
  always @(posedge clk) begin
    if (rst_n) begin
      model_reg = ref_fn(bus.opcode, bus.A, bus.B);
      exp_q.push_back(model_reg);
    end
  end

  always @(negedge rst_n) begin
    model_reg = 8'h00;
    exp_q.delete();
  end

  // Compare process, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      chk("reset_hold", bus.ALU_Out, 8'h00);
    end else if (exp_q.size() > 0) begin
      chk("scoreboard", bus.ALU_Out, exp_q.pop_front());
    end
  end

  task automatic drive(input logic [3:0] op, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    #1;
    bus.opcode = op;
    bus.A = a;
    bus.B = b;
  endtask

  task automatic lit(input string name, input logic [3:0] op, input logic [7:0] a,
                     input logic [7:0] b, input logic [7:0] expv);
    drive(op, a, b);
    chk({name, "_model"}, ref_fn(op, a, b), expv);
    @(posedge clk);
    #1;
    chk(name, bus.ALU_Out, expv);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] edge_vals[4];
    logic [7:0] a;
    logic [7:0] b;
    edge_vals[0] = 8'h00;
    edge_vals[1] = 8'hFF;
    edge_vals[2] = 8'h01;
    edge_vals[3] = 8'h80;

    bus.opcode = 4'h0;
    bus.A = 8'h00;
    bus.B = 8'h00;
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", bus.ALU_Out, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;

    // Directed vectors
    lit("add_1_1",   4'b0000, 8'h01, 8'h01, 8'h02);
    lit("add_a_5",   4'b0000, 8'h0A, 8'h05, 8'h0F);
    lit("sub_ff_ff", 4'b0001, 8'hFF, 8'hFF, 8'h00);
    lit("sub_wrap",  4'b0001, 8'h00, 8'h01, 8'hFF);
    lit("sub_a_5",   4'b0001, 8'h0A, 8'h05, 8'h05);
    lit("mul",       4'b0010, 8'h10, 8'h11, 8'h10);
    lit("div",       4'b0011, 8'h0F, 8'h04, 8'h03);
    lit("div_zero",  4'b0011, 8'h0F, 8'h00, 8'h00);
    lit("rol",       4'b0110, 8'h81, 8'h00, 8'h03);
    lit("ror",       4'b0111, 8'h81, 8'h00, 8'hC0);
    lit("shl",       4'b0100, 8'h81, 8'h00, 8'h02);
    lit("shr",       4'b0101, 8'h81, 8'h00, 8'h40);
    lit("and",       4'b1000, 8'hF0, 8'h3C, 8'h30);
    lit("xor",       4'b1010, 8'hF0, 8'h3C, 8'hCC);
    lit("nand",      4'b1100, 8'hF0, 8'h3C, 8'hCF);
    lit("or",        4'b1001, 8'hF0, 8'h3C, 8'hFC);
    lit("nor",       4'b1011, 8'hF0, 8'h3C, 8'h03);
    lit("xnor",      4'b1101, 8'hF0, 8'h3C, 8'h33);
    lit("eq_equal",  4'b1111, 8'h05, 8'h05, 8'h01);
    lit("gt_equal",  4'b1110, 8'h05, 8'h05, 8'h00);
    lit("gt_true",   4'b1110, 8'h06, 8'h05, 8'h01);

    // Mid-cycle input changes must not reach the output before the next edge.
    lit("hold_setup", 4'b0000, 8'h03, 8'h04, 8'h07);
    #2;
    bus.opcode = 4'b0010;
    bus.A = 8'hFF;
    #1;
    bus.B = 8'h33;
    #1;
    chk("hold_between_edges", bus.ALU_Out, model_reg);

    // Asynchronous reset between edges, held, then released.
    lit("pre_reset_add", 4'b0000, 8'h0A, 8'h05, 8'h0F);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_reset", bus.ALU_Out, 8'h00);
    repeat (2) @(posedge clk);
    #1;
    chk("reset_held", bus.ALU_Out, 8'h00);
    @(negedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_reset", bus.ALU_Out, 8'h0F);

    // Randomized traffic with occasional reset pulses.
    for (int i = 0; i < 3000; i++) begin
      a = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 3)] : 8'($urandom);
      b = ($urandom_range(0, 7) == 0) ? edge_vals[$urandom_range(0, 3)] : 8'($urandom);
      drive(4'($urandom_range(0, 15)), a, b);
      if ($urandom_range(0, 199) == 0) begin
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        rst_n = 1'b1;
      end
    end

    repeat (2) @(negedge clk);
    #1;
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
